// File: rtl/simple_serial_engine.sv
// Serial frame engine: chip select, MSB-first shift of up to 32 bits with concurrent capture.
// Define SIMPLE_SERIAL_LSB_FIRST_EN to shift and capture LSB-first instead.
module simple_serial_engine #(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        serial_clk,
    input  logic        serial_rst,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_len,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        cs_b,
    output logic        pico,
    input  logic        poci,
    output logic [2:0]  dbg_status,
    output logic [5:0]  dbg_current_bit
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [4:0]  last_q, last_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rx_q, rx_d;
    logic        tx_ready_q, tx_ready_d;
    logic        rx_valid_q, rx_valid_d;
    logic        cs_b_q, cs_b_d;
    logic        pico_q, pico_d;
    logic [5:0]  dbg_bit_q, dbg_bit_d;
    logic [4:0]  first_idx_s;
    logic        last_bit_s;
    logic        first_bit_s;
    logic [4:0]  step_idx_s;

    // last_q holds N-1; the walk direction depends on bit order
`ifdef SIMPLE_SERIAL_LSB_FIRST_EN
    assign first_idx_s = 5'd0;
    assign first_bit_s = (bit_q == 5'd0);
    assign last_bit_s  = (bit_q == last_q);
    assign step_idx_s  = bit_q + 5'd1;
`else
    assign first_idx_s = last_q;
    assign first_bit_s = (bit_q == last_q);
    assign last_bit_s  = (bit_q == 5'd0);
    assign step_idx_s  = bit_q - 5'd1;
`endif

    // Next-state, datapath and next-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        last_d  = last_q;
        data_d  = data_q;
        rx_d    = rx_q;
        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    state_d = SETUP;
                    cnt_d   = 4'd0;
                    data_d  = tx_data;
                    last_d  = ((tx_len == 6'd0) || (tx_len > 6'd32)) ? 5'd31 : (tx_len[4:0] - 5'd1);
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == 4'(SETUP_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = 4'd0;
                    bit_d   = first_idx_s;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SHIFT: begin
                rx_d        = first_bit_s ? 32'd0 : rx_q;
                rx_d[bit_q] = poci;
                if (last_bit_s) begin
                    state_d = HOLD;
                    cnt_d   = 4'd0;
                end else begin
                    bit_d = step_idx_s;
                end
            end
            HOLD: begin
                if (cnt_q == 4'(HOLD_CYCLES - 1)) begin
                    state_d = GAP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        tx_ready_d = (state_d == IDLE);
        rx_valid_d = (state_d == GAP) && (state_q == HOLD);
        cs_b_d     = (state_d == IDLE) || (state_d == GAP);
        pico_d     = (state_d == SHIFT) ? data_d[bit_d] : 1'b0;
        dbg_bit_d  = (state_d == SHIFT) ? {1'b0, bit_d} : 6'd0;
    end

    // State and registered outputs
    always_ff @(posedge serial_clk) begin
        if (serial_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            bit_q      <= 5'd0;
            last_q     <= 5'd0;
            data_q     <= 32'd0;
            rx_q       <= 32'd0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            cs_b_q     <= 1'b1;
            pico_q     <= 1'b0;
            dbg_bit_q  <= 6'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            data_q     <= data_d;
            rx_q       <= rx_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            cs_b_q     <= cs_b_d;
            pico_q     <= pico_d;
            dbg_bit_q  <= dbg_bit_d;
        end
    end

    assign tx_ready        = tx_ready_q;
    assign rx_data         = rx_q;
    assign rx_valid        = rx_valid_q;
    assign cs_b            = cs_b_q;
    assign pico            = pico_q;
    assign dbg_status      = state_q;
    assign dbg_current_bit = dbg_bit_q;

endmodule

// File: tb/tb_simple_serial_engine.sv
// Randomized self-checking bench for simple_serial_engine against a frame-level reference model.
module tb_simple_serial_engine;

    localparam int S = 1;
    localparam int H = 1;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_data = 32'd0;
    logic [5:0]  tx_len = 6'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        cs_b;
    logic        pico;
    logic        poci;
    logic [2:0]  dbg_status;
    logic [5:0]  dbg_current_bit;
    logic        loop_en = 1'b1;
    logic        poci_drv = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rx;

    always #5 clk = ~clk;

    assign poci = loop_en ? pico : poci_drv;

    simple_serial_engine #(.SETUP_CYCLES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .serial_clk(clk), .serial_rst(rst), .tx_data(tx_data), .tx_len(tx_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .cs_b(cs_b), .pico(pico), .poci(poci), .dbg_status(dbg_status),
        .dbg_current_bit(dbg_current_bit)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit index of the j-th serial slot of an n-bit frame
    function automatic int slot_idx(input int j, input int n);
`ifdef SIMPLE_SERIAL_LSB_FIRST_EN
        return j;
`else
        return n - 1 - j;
`endif
    endfunction

    task automatic wait_ready(input string tag);
        int c = 0;
        while (tx_ready !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check_val(tag, 64'(tx_ready), 64'd1);
    endtask

    // pmode: 0 loopback, 1 tied 0, 2 tied 1, 3 random
    task automatic run_frame(input logic [31:0] d, input logic [5:0] l, input int pmode);
        int n, k, j, idx, cyc, lowcnt, pulses, pulse_at;
        bit pico_ok, dbg_ok, st_ok;
        logic p;
        logic [31:0] exp_rx, got_rx;
        n = (l == 6'd0 || l > 6'd32) ? 32 : int'(l);
        k = 0; cyc = 0; lowcnt = 0; pulses = 0; pulse_at = -1;
        pico_ok = 1'b1; dbg_ok = 1'b1; st_ok = 1'b1;
        exp_rx = 32'd0; got_rx = 32'd0;
        wait_ready("ready_before_frame");
        loop_en  = (pmode == 0);
        poci_drv = (pmode == 2);
        tx_data  = d;
        tx_len   = l;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = $urandom;
        tx_len   = 6'($urandom);
        while (cyc < 200) begin
            @(negedge clk);
            if (tx_ready === 1'b1) break;
            cyc++;
            if (rx_valid === 1'b1) begin
                pulses++;
                pulse_at = cyc;
                got_rx = rx_data;
            end
            if (cs_b === 1'b0) begin
                lowcnt++;
                if (k >= S && k < S + n) begin
                    j = k - S;
                    idx = slot_idx(j, n);
                    if (pico !== d[idx]) pico_ok = 1'b0;
                    if (dbg_current_bit !== 6'(idx)) dbg_ok = 1'b0;
                    if (dbg_status !== 3'd2) st_ok = 1'b0;
                    if (pmode == 3) poci_drv = 1'($urandom);
                    p = (pmode == 0) ? pico : poci_drv;
                    exp_rx[idx] = p;
                end else begin
                    if (pico !== 1'b0) pico_ok = 1'b0;
                    if (dbg_current_bit !== 6'd0) dbg_ok = 1'b0;
                    if (dbg_status !== ((k < S) ? 3'd1 : 3'd3)) st_ok = 1'b0;
                end
                k++;
            end else begin
                if (dbg_status !== 3'd4 || pico !== 1'b0) st_ok = 1'b0;
            end
        end
        check_val("frame_latency", 64'(cyc + 1), 64'(1 + S + n + H + G));
        check_val("cs_low_cycles", 64'(lowcnt), 64'(S + n + H));
        check_val("pico_sequence", 64'(pico_ok), 64'd1);
        check_val("dbg_current_bit", 64'(dbg_ok), 64'd1);
        check_val("dbg_status", 64'(st_ok), 64'd1);
        check_val("rx_valid_count", 64'(pulses), 64'd1);
        check_val("rx_valid_timing", 64'(pulse_at), 64'(S + n + H + 1));
        check_val("rx_data", 64'(got_rx), 64'(exp_rx));
        check_val("rx_data_hold", 64'(rx_data), 64'(exp_rx));
        last_rx = got_rx;
    endtask

    task automatic back_to_back();
        int c, low1, low2, hi;
        bit ready_bad;
        c = 0; low1 = 0; low2 = 0; hi = 0; ready_bad = 1'b0;
        wait_ready("b2b_ready");
        loop_en = 1'b0; poci_drv = 1'b0;
        tx_data = $urandom; tx_len = 6'd8; tx_valid = 1'b1;
        @(negedge clk);
        while (cs_b !== 1'b0 && c < 50) begin @(negedge clk); c++; end
        while (cs_b === 1'b0 && c < 100) begin
            low1++; c++;
            if (tx_ready !== 1'b0) ready_bad = 1'b1;
            @(negedge clk);
        end
        while (cs_b === 1'b1 && c < 150) begin hi++; c++; @(negedge clk); end
        tx_valid = 1'b0;
        while (cs_b === 1'b0 && c < 200) begin
            low2++; c++;
            if (tx_ready !== 1'b0) ready_bad = 1'b1;
            @(negedge clk);
        end
        check_val("b2b_frame1_low", 64'(low1), 64'(S + 8 + H));
        check_val("b2b_gap_high", 64'(hi), 64'(G + 1));
        check_val("b2b_frame2_low", 64'(low2), 64'(S + 8 + H));
        check_val("b2b_ready_low", 64'(ready_bad), 64'd0);
    endtask

    task automatic reset_midframe();
        int pulses = 0;
        wait_ready("rst_ready");
        loop_en = 1'b1;
        tx_data = 32'h0000_00A5; tx_len = 6'd8; tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (S + 3) @(negedge clk);
        check_val("rst_in_shift3", 64'(dbg_status), 64'd2);
        check_val("rst_shift3_bit", 64'(dbg_current_bit), 64'(slot_idx(2, 8)));
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_cs_b", 64'(cs_b), 64'd1);
        check_val("rst_pico", 64'(pico), 64'd0);
        check_val("rst_tx_ready", 64'(tx_ready), 64'd0);
        check_val("rst_status", 64'(dbg_status), 64'd0);
        check_val("rst_rx_data", 64'(rx_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready_after", 64'(tx_ready), 64'd1);
        repeat (12) begin
            if (rx_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        check_val("rst_no_rx_valid", 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_cs_b", 64'(cs_b), 64'd1);
        check_val("reset_pico", 64'(pico), 64'd0);
        check_val("reset_tx_ready", 64'(tx_ready), 64'd0);
        check_val("reset_rx_valid", 64'(rx_valid), 64'd0);
        check_val("reset_rx_data", 64'(rx_data), 64'd0);
        check_val("reset_status", 64'(dbg_status), 64'd0);
        check_val("reset_bit", 64'(dbg_current_bit), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("ready_after_reset", 64'(tx_ready), 64'd1);

        run_frame(32'h0000_00A5, 6'd8, 0);
        check_val("a5_loopback_rx", 64'(last_rx), 64'h0000_00A5);
        run_frame(32'h8000_0001, 6'd0, 2);
        check_val("len0_tied1_rx", 64'(last_rx), 64'hFFFF_FFFF);
        run_frame(32'h0000_000F, 6'd40, 1);
        check_val("len40_tied0_rx", 64'(last_rx), 64'd0);
        run_frame(32'h0000_0001, 6'd4, 0);
        check_val("len4_loopback_rx", 64'(last_rx), 64'd1);
        run_frame(32'h0000_0001, 6'd1, 0);

        back_to_back();
        reset_midframe();

        for (int i = 0; i < 20; i++) begin
            run_frame($urandom, 6'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_serial_engine.md
SIMPLE_SERIAL_ENGINE -- requirements
Module: simple_serial_engine

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: serial_clk cycles with cs_b low before the first bit; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 1: serial_clk cycles with cs_b low after the last bit; legal range 1..15.
REQ-003 Parameter GAP_CYCLES, default 2: minimum serial_clk cycles with cs_b high between frames; legal range 1..15.
REQ-004 serial_clk  input  1  sole clock; every flop updates on its rising edge.
REQ-005 serial_rst  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  32  frame payload; bits above the frame length are ignored.
REQ-007 tx_len  input  6  frame length in bits; 1..32 literal, 0 means 32, 33..63 saturate to 32.
REQ-008 tx_valid  input  1  upstream offers a frame.
REQ-009 tx_ready  output  1  engine accepts a frame this cycle.
REQ-010 rx_data  output  32  bits captured from poci, right-aligned, zero-extended.
REQ-011 rx_valid  output  1  one-cycle pulse qualifying rx_data.
REQ-012 cs_b  output  1  active-low chip select.
REQ-013 pico  output  1  serial data to the peripheral.
REQ-014 poci  input  1  serial data from the peripheral, synchronous to serial_clk.
REQ-015 dbg_status  output  3  current FSM state code.
REQ-016 dbg_current_bit  output  6  index of the bit currently on pico.

Function
REQ-017 The FSM SHALL have the states IDLE=0, SETUP=1, SHIFT=2, HOLD=3 and GAP=4, and dbg_status SHALL equal the current state code.
REQ-018 tx_ready SHALL be 1 only in IDLE, and a frame SHALL be accepted on the edge where tx_valid and tx_ready are both 1.
- On acceptance: latch tx_data and the effective length N, then go to SETUP.
REQ-019 In SETUP, cs_b SHALL be 0 and pico SHALL be 0 for SETUP_CYCLES cycles, after which the FSM SHALL go to SHIFT.
REQ-020 In SHIFT, the FSM SHALL drive exactly one bit per cycle for N cycles.
- Bit order is MSB-first: bit N-1 first, bit 0 last.
- dbg_current_bit SHALL equal the index of the bit being driven.
- dbg_current_bit SHALL be 0 in all other states.
REQ-021 On each SHIFT edge, poci SHALL be sampled and shifted into the receive register.
- rx_data bit N-1 = first sampled bit; rx_data bit 0 = last sampled bit.
- rx_data bits 31..N = 0.
REQ-022 After the Nth SHIFT cycle, the FSM SHALL go to HOLD.
- HOLD: cs_b=0, pico=0, for HOLD_CYCLES cycles; then go to GAP.
REQ-023 On entry to GAP, rx_valid SHALL pulse for exactly one cycle, and rx_data SHALL hold its value until the next frame's first SHIFT edge.
REQ-024 In GAP, cs_b SHALL be 1 and pico SHALL be 0 for GAP_CYCLES cycles, after which the FSM SHALL return to IDLE.
REQ-025 Back-to-back frames: cs_b SHALL be high for a minimum of GAP_CYCLES+1 cycles.
REQ-026 tx_valid asserted outside IDLE SHALL be ignored, and the frame SHALL be held upstream until tx_ready.
REQ-027 Changes on tx_data and tx_len after acceptance SHALL NOT affect the frame in flight.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-029 One frame SHALL take 1 + SETUP_CYCLES + N + HOLD_CYCLES + GAP_CYCLES cycles from acceptance to tx_ready=1.

Reset
REQ-030 While serial_rst=1, outputs SHALL be: cs_b=1, pico=0, tx_ready=0, rx_valid=0, rx_data=0, dbg_status=0, dbg_current_bit=0.
REQ-031 On the first edge with serial_rst=0, the FSM SHALL be in IDLE with tx_ready=1 on the following cycle.
REQ-032 Reset asserted mid-frame SHALL abort the frame.
- cs_b returns high on that edge.
- No rx_valid pulse is issued for the aborted frame.

Configuration
REQ-033 Macro SIMPLE_SERIAL_LSB_FIRST_EN SHALL select the bit order.
- Undefined: MSB-first, per REQ-020 and REQ-021.
- Defined: bit 0 is driven first and bit N-1 last; dbg_current_bit counts up from 0.
- Defined: the first sampled poci bit lands in rx_data bit 0 and the last in bit N-1; bits 31..N = 0.
- All timing is identical in both modes.

Verification
REQ-034 Default parameters, MSB mode, tx_data=0xA5, tx_len=8, poci looped to pico:
- pico sequence 1,0,1,0,0,1,0,1.
- cs_b low for exactly 10 cycles.
- rx_data=0x000000A5 with one rx_valid pulse.
REQ-035 tx_len=0, tx_data=0x80000001, poci tied 1:
- 32 SHIFT cycles; first bit 1, last bit 1.
- rx_data=0xFFFFFFFF.
REQ-036 tx_len=40, tx_data=0x0000000F, poci tied 0:
- Frame saturates to 32 bits: 28 zeros then 4 ones.
- rx_data=0.
REQ-037 tx_valid held high with two queued frames, default parameters:
- cs_b high for exactly 3 cycles between the frames.
- tx_ready low throughout both frames.
REQ-038 serial_rst pulsed during the 3rd SHIFT cycle of an 8-bit frame:
- cs_b=1 and pico=0 on the next edge.
- No rx_valid pulse.
- tx_ready=1 one cycle after reset deasserts.
REQ-039 SIMPLE_SERIAL_LSB_FIRST_EN defined, tx_data=0x01, tx_len=4, loopback:
- pico sequence 1,0,0,0.
- rx_data=0x00000001.
